mod_dispatcher: RTL

MOD_DISPATCHER -- requirements
Module: mod_dispatcher

---
 rtl/mod_pkg.sv | 22 ++
 rtl/mod_dispatcher_if.sv | 32 +++
 rtl/lowest_bit_pick.sv | 28 ++
 rtl/mod_dispatcher.sv | 149 ++++++++++++++
 4 files changed

// File: rtl/mod_pkg.sv
// ---------------------------------------------------------------------------
// mod_pkg
// Shared definitions for the dispatcher and its helpers:
//   state_t                 dispatcher FSM state encoding
//   INDEX_W / NUM_IDX       width of a checker index / number of indices
//   TIMEOUT_CYCLES_DEFAULT  default WAIT budget before a done is declared lost
// ---------------------------------------------------------------------------
package mod_pkg;

    localparam int INDEX_W = 3;
    localparam int NUM_IDX = 8;
    localparam int unsigned TIMEOUT_CYCLES_DEFAULT = 15;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        PICK   = 3'd1,
        ISSUE  = 3'd2,
        WAIT   = 3'd3,
        FINISH = 3'd4
    } state_t;

endpackage

// File: rtl/mod_dispatcher_if.sv
// ---------------------------------------------------------------------------
// mod_dispatcher_if
// Bundles the dispatcher's request, checker handshake and result signals.
//   slave  : the dispatcher itself (takes start/mask/chk_done/chk_index_ret,
//            drives busy/chk_en/chk_index/result/pass_done/error)
//   master : the requester plus checker side (opposite directions)
// ---------------------------------------------------------------------------
interface mod_dispatcher_if;
    import mod_pkg::*;

    logic               start;
    logic [NUM_IDX-1:0] mask;
    logic               busy;
    logic               chk_en;
    logic [INDEX_W-1:0] chk_index;
    logic               chk_done;
    logic [INDEX_W-1:0] chk_index_ret;
    logic [NUM_IDX-1:0] result;
    logic               pass_done;
    logic               error;

    modport slave (
        input  start, mask, chk_done, chk_index_ret,
        output busy, chk_en, chk_index, result, pass_done, error
    );

    modport master (
        output start, mask, chk_done, chk_index_ret,
        input  busy, chk_en, chk_index, result, pass_done, error
    );

endinterface

// File: rtl/lowest_bit_pick.sv
// ---------------------------------------------------------------------------
// lowest_bit_pick
// Combinational priority encoder: returns the index of the lowest set bit.
//   vec   in  NUM_IDX  candidate bits
//   index out INDEX_W  position of the lowest set bit (0 when vec is empty)
//   valid out 1        at least one bit of vec is set
// ---------------------------------------------------------------------------
module lowest_bit_pick
    import mod_pkg::*;
(
    input  logic [NUM_IDX-1:0] vec,
    output logic [INDEX_W-1:0] index,
    output logic               valid
);

    // Scan from the top down so the last hit, i.e. the lowest bit, wins.
    always_comb begin
        index = '0;
        valid = 1'b0;
        for (int i = NUM_IDX - 1; i >= 0; i--) begin
            if (vec[i]) begin
                index = INDEX_W'(i);
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mod_dispatcher.sv
// ---------------------------------------------------------------------------
// mod_dispatcher
// Walks the set bits of a captured mask, lowest first, issuing one request
// per index to a downstream checker and collecting confirmations into result.
//
// Ports:
//   clk   in  single clock, rising edge
//   rst   in  asynchronous, active-low reset
//   bus   mod_dispatcher_if.slave
//         start/mask            pass request, sampled only in IDLE
//         busy                  accepted start .. pass_done inclusive
//         chk_en/chk_index      one-cycle request to the checker
//         chk_done/chk_index_ret checker answer, honoured only in WAIT
//         result/pass_done/error pass outcome
//
// Parameter TIMEOUT_CYCLES: WAIT cycles allowed before a missing done is lost.
// Build option: define MOD_DISPATCHER_TIMEOUT_EN to enable the WAIT timeout;
// without it WAIT exits only on chk_done and TIMEOUT_CYCLES is unused.
//
// All outputs are registered and set on the edge that enters the state they
// belong to, so chk_en is high exactly during ISSUE and pass_done exactly
// during FINISH.
// ---------------------------------------------------------------------------
module mod_dispatcher
    import mod_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
    input  logic            clk,
    input  logic            rst,
    mod_dispatcher_if.slave bus
);

    state_t             state_reg;
    logic [NUM_IDX-1:0] pending_reg;
    logic [NUM_IDX-1:0] result_reg;
    logic [INDEX_W-1:0] chk_index_reg;
    logic               busy_reg;
    logic               chk_en_reg;
    logic               pass_done_reg;
    logic               error_reg;

    logic [INDEX_W-1:0] pick_index;
    logic               pick_valid;

`ifdef MOD_DISPATCHER_TIMEOUT_EN
    // Two extra codes of headroom keep the width non-zero for tiny budgets.
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 2);
    logic [CNT_W-1:0] cnt_reg;
`endif

    lowest_bit_pick u_pick (
        .vec   (pending_reg),
        .index (pick_index),
        .valid (pick_valid)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg     <= IDLE;
            pending_reg   <= '0;
            result_reg    <= '0;
            chk_index_reg <= '0;
            busy_reg      <= 1'b0;
            chk_en_reg    <= 1'b0;
            pass_done_reg <= 1'b0;
            error_reg     <= 1'b0;
`ifdef MOD_DISPATCHER_TIMEOUT_EN
            cnt_reg       <= '0;
`endif
        end else begin
            // Pulses default low; they are raised only on entry to their state.
            chk_en_reg    <= 1'b0;
            pass_done_reg <= 1'b0;

            case (state_reg)
                IDLE: begin
                    if (bus.start) begin
                        pending_reg <= bus.mask;
                        result_reg  <= '0;
                        error_reg   <= 1'b0;
                        busy_reg    <= 1'b1;
                        state_reg   <= PICK;
                    end
                end

                PICK: begin
                    if (!pick_valid) begin
                        pass_done_reg <= 1'b1;
                        state_reg     <= FINISH;
                    end else begin
                        chk_index_reg           <= pick_index;
                        pending_reg[pick_index] <= 1'b0;
                        chk_en_reg              <= 1'b1;
                        state_reg               <= ISSUE;
                    end
                end

                ISSUE: begin
`ifdef MOD_DISPATCHER_TIMEOUT_EN
                    cnt_reg <= CNT_W'(TIMEOUT_CYCLES);
`endif
                    state_reg <= WAIT;
                end

                WAIT: begin
                    if (bus.chk_done) begin
                        // A done carrying the wrong index still ends the wait;
                        // it just does not confirm the requested index.
                        if (bus.chk_index_ret == chk_index_reg) begin
                            result_reg[chk_index_reg] <= 1'b1;
                        end else begin
                            error_reg <= 1'b1;
                        end
                        state_reg <= PICK;
                    end
`ifdef MOD_DISPATCHER_TIMEOUT_EN
                    // The counter value is the number of WAIT cycles left,
                    // including the current one.
                    else if (cnt_reg <= CNT_W'(1)) begin
                        cnt_reg   <= '0;
                        error_reg <= 1'b1;
                        state_reg <= PICK;
                    end else begin
                        cnt_reg <= cnt_reg - 1'b1;
                    end
`endif
                end

                FINISH: begin
                    busy_reg  <= 1'b0;
                    state_reg <= IDLE;
                end

                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy      = busy_reg;
    assign bus.chk_en    = chk_en_reg;
    assign bus.chk_index = chk_index_reg;
    assign bus.result    = result_reg;
    assign bus.pass_done = pass_done_reg;
    assign bus.error     = error_reg;

endmodule
